bus_multicaster: RTL and testbench

//  Column-side end of the BUS<->MultiCaster link and driver end of the MultiCaster->PE link.
//  - Accepts {ifmap, fltr, psum} beats broadcast on the column bus when CASTER_EN=1 and TAG==ID.
//  - Buffers beats and issues them to one PE under an outstanding-credit limit.
//  - Collects PE results and returns them to the bus with a VALID/READY handshake.

---
 rtl/mc_pkg.sv | 23 ++
 rtl/mc_sync_fifo.sv | 52 +++++
 rtl/bus_multicaster.sv | 181 ++++++++++++++++++
 tb/tb_bus_multicaster.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types for the bus_multicaster column link.
//  mc_beat_t  : one {ifmap, fltr, psum} beat as carried on every link
//  mc_state_e : kernel-size control state
package mc_pkg;

   localparam int MC_DATA_WIDTH = 16;
   localparam int MC_OUTST_W    = 4;

   typedef struct packed {
      logic [MC_DATA_WIDTH-1:0]   ifmap;
      logic [MC_DATA_WIDTH-1:0]   fltr;
      logic [2*MC_DATA_WIDTH-1:0] psum;
   } mc_beat_t;

   localparam int MC_BEAT_W = $bits(mc_beat_t);

   typedef enum logic [1:0] {
      MC_IDLE   = 2'd0,
      MC_ACTIVE = 2'd1,
      MC_DRAIN  = 2'd2
   } mc_state_e;

endpackage

// File: rtl/mc_sync_fifo.sv
// Single-clock FIFO used for both the forward (bus->PE) and return (PE->bus) paths.
//  clk, rst : clock, asynchronous active-high reset (pointers only)
//  push/din : write request and data; accepted when not full, or when full and popping
//  pop      : read request; ignored when empty
//  full/empty/head : status and the oldest entry (valid when !empty)
module mc_sync_fifo
   import mc_pkg::*;
#(
   parameter int WIDTH = MC_BEAT_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when the index bits match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/bus_multicaster.sv
// Column-side end of the bus<->multicaster link and driver of the multicaster->PE link.
// Beats addressed to this column (CASTER_EN & TAG==ID) are buffered and issued to the PE
// under an outstanding-credit limit; PE results are buffered and returned with VALID/READY.
//  clk, rst                     : clock, asynchronous active-high reset
//  ID, TAG, CASTER_EN           : column address, beat destination, beat present
//  *_data_B2M, kernel_size      : incoming bus beat
//  VALID, READY, *_data_M2B     : returned beat handshake toward the bus
//  PE_EN, *_data_M2P            : registered 1-cycle forward strobe and beat to the PE
//  pe_kernel_size               : kernel size latched at the start of a burst
//  PE_VALID, PE_READY, *_P2M    : PE result handshake
//  ovf_err                      : sticky, a matching beat was dropped on a full forward FIFO
module bus_multicaster
   import mc_pkg::*;
#(
   parameter int DATA_WIDTH = MC_DATA_WIDTH,
   parameter int NUM_COL    = 4,
   parameter int FWD_DEPTH  = 4,
   parameter int RET_DEPTH  = 2,
   parameter int MAX_OUTST  = 2,
   localparam int NCW       = $clog2(NUM_COL)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NCW-1:0]          ID,
   input  logic [NCW-1:0]          TAG,
   input  logic                    CASTER_EN,
   input  logic [DATA_WIDTH-1:0]   ifmap_data_B2M,
   input  logic [DATA_WIDTH-1:0]   fltr_data_B2M,
   input  logic [2*DATA_WIDTH-1:0] psum_data_B2M,
   input  logic [7:0]              kernel_size,
   input  logic                    READY,
   output logic                    VALID,
   output logic [DATA_WIDTH-1:0]   ifmap_data_M2B,
   output logic [DATA_WIDTH-1:0]   fltr_data_M2B,
   output logic [2*DATA_WIDTH-1:0] psum_data_M2B,
   output logic                    PE_EN,
   output logic [DATA_WIDTH-1:0]   ifmap_data_M2P,
   output logic [DATA_WIDTH-1:0]   fltr_data_M2P,
   output logic [2*DATA_WIDTH-1:0] psum_data_M2P,
   output logic [7:0]              pe_kernel_size,
   output logic                    PE_READY,
   input  logic                    PE_VALID,
   input  logic [DATA_WIDTH-1:0]   ifmap_data_P2M,
   input  logic [DATA_WIDTH-1:0]   fltr_data_P2M,
   input  logic [2*DATA_WIDTH-1:0] psum_data_P2M,
   output logic                    ovf_err
);

   localparam logic [MC_OUTST_W-1:0] OUTST_LIMIT = MC_OUTST_W'(MAX_OUTST);

   mc_state_e             state;
   mc_state_e             state_nxt;
   logic [MC_OUTST_W-1:0] outst;
   logic [MC_OUTST_W-1:0] outst_nxt;

   mc_beat_t fwd_in;
   mc_beat_t fwd_head;
   mc_beat_t ret_in;
   mc_beat_t ret_head;
   logic     fwd_full;
   logic     fwd_empty;
   logic     ret_full;
   logic     ret_empty;

   logic acc;
   logic issue;
   logic drop;
   logic ret_push;
   logic ret_pop;
   logic ret_dec;
   logic pipe_idle;

   assign acc      = CASTER_EN && (TAG == ID);
   assign issue    = !fwd_empty && (outst < OUTST_LIMIT);
   // The bus cannot be stalled, so a matching beat with nowhere to go is lost.
   assign drop     = acc && fwd_full && !issue;
   assign PE_READY = !ret_full;
   assign ret_push = PE_VALID && !ret_full;
   assign ret_pop  = READY && !ret_empty;
   // A result with no beat in flight cannot retire a credit; keeps the counter from wrapping.
   assign ret_dec  = ret_push && (outst != '0);
   assign pipe_idle = fwd_empty && (outst == '0);

   assign fwd_in.ifmap = ifmap_data_B2M;
   assign fwd_in.fltr  = fltr_data_B2M;
   assign fwd_in.psum  = psum_data_B2M;
   assign ret_in.ifmap = ifmap_data_P2M;
   assign ret_in.fltr  = fltr_data_P2M;
   assign ret_in.psum  = psum_data_P2M;

   mc_sync_fifo #(.WIDTH(MC_BEAT_W), .DEPTH(FWD_DEPTH)) u_fwd (
      .clk   (clk),
      .rst   (rst),
      .push  (acc),
      .pop   (issue),
      .din   (fwd_in),
      .full  (fwd_full),
      .empty (fwd_empty),
      .head  (fwd_head)
   );

   mc_sync_fifo #(.WIDTH(MC_BEAT_W), .DEPTH(RET_DEPTH)) u_ret (
      .clk   (clk),
      .rst   (rst),
      .push  (ret_push),
      .pop   (ret_pop),
      .din   (ret_in),
      .full  (ret_full),
      .empty (ret_empty),
      .head  (ret_head)
   );

   // Return path shows zeros while empty so the bus never sees stale storage.
   assign VALID          = !ret_empty;
   assign ifmap_data_M2B = ret_empty ? '0 : ret_head.ifmap;
   assign fltr_data_M2B  = ret_empty ? '0 : ret_head.fltr;
   assign psum_data_M2B  = ret_empty ? '0 : ret_head.psum;

   // Issue register: the M2P bus holds the last beat between strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PE_EN          <= 1'b0;
         ifmap_data_M2P <= '0;
         fltr_data_M2P  <= '0;
         psum_data_M2P  <= '0;
      end else begin
         PE_EN <= issue;
         if (issue) begin
            ifmap_data_M2P <= fwd_head.ifmap;
            fltr_data_M2P  <= fwd_head.fltr;
            psum_data_M2P  <= fwd_head.psum;
         end
      end
   end

   always_comb begin
      outst_nxt = outst;
      if (issue && !ret_dec)
         outst_nxt = outst + MC_OUTST_W'(1);
      else if (!issue && ret_dec)
         outst_nxt = outst - MC_OUTST_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outst          <= '0;
         ovf_err        <= 1'b0;
         pe_kernel_size <= '0;
      end else begin
         outst <= outst_nxt;
         if (drop) ovf_err <= 1'b1;
         if ((state == MC_IDLE) && acc) pe_kernel_size <= kernel_size;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= MC_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MC_IDLE: begin
            if (acc) state_nxt = MC_ACTIVE;
         end
         MC_ACTIVE: begin
            if (!CASTER_EN) begin
               if (!pipe_idle)     state_nxt = MC_DRAIN;
               else if (ret_empty) state_nxt = MC_IDLE;
            end
         end
         MC_DRAIN: begin
            if (acc)                         state_nxt = MC_ACTIVE;
            else if (pipe_idle && ret_empty) state_nxt = MC_IDLE;
         end
         default: state_nxt = MC_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bus_multicaster.sv
module tb_bus_multicaster;

   localparam int         DW        = 16;
   localparam int         FWD_DEPTH = 4;
   localparam int         RET_DEPTH = 2;
   localparam int         MAX_OUTST = 2;
   localparam logic [1:0] MY_ID     = 2'd2;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    id;
   logic [1:0]    tag;
   logic          caster_en;
   logic [DW-1:0] ifmap_b2m, fltr_b2m;
   logic [2*DW-1:0] psum_b2m;
   logic [7:0]    kernel_size;
   logic          ready;
   logic          valid;
   logic [DW-1:0] ifmap_m2b, fltr_m2b;
   logic [2*DW-1:0] psum_m2b;
   logic          pe_en;
   logic [DW-1:0] ifmap_m2p, fltr_m2p;
   logic [2*DW-1:0] psum_m2p;
   logic [7:0]    pe_kernel_size;
   logic          pe_ready;
   logic          pe_valid;
   logic [DW-1:0] ifmap_p2m, fltr_p2m;
   logic [2*DW-1:0] psum_p2m;
   logic          ovf_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: queues of beats plus counters, advanced once per clock edge.
   logic [63:0] fq[$];
   logic [63:0] rq[$];
   int          m_outst;
   logic        m_ovf;
   logic        m_pe_en;
   logic [63:0] m_m2p;
   logic [7:0]  m_pks;
   int          m_st;   // 0 idle, 1 active, 2 drain

   bus_multicaster #(
      .DATA_WIDTH(DW), .NUM_COL(4), .FWD_DEPTH(FWD_DEPTH),
      .RET_DEPTH(RET_DEPTH), .MAX_OUTST(MAX_OUTST)
   ) dut (
      .clk(clk), .rst(rst), .ID(id), .TAG(tag), .CASTER_EN(caster_en),
      .ifmap_data_B2M(ifmap_b2m), .fltr_data_B2M(fltr_b2m), .psum_data_B2M(psum_b2m),
      .kernel_size(kernel_size), .READY(ready), .VALID(valid),
      .ifmap_data_M2B(ifmap_m2b), .fltr_data_M2B(fltr_m2b), .psum_data_M2B(psum_m2b),
      .PE_EN(pe_en), .ifmap_data_M2P(ifmap_m2p), .fltr_data_M2P(fltr_m2p),
      .psum_data_M2P(psum_m2p), .pe_kernel_size(pe_kernel_size), .PE_READY(pe_ready),
      .PE_VALID(pe_valid), .ifmap_data_P2M(ifmap_p2m), .fltr_data_P2M(fltr_p2m),
      .psum_data_P2M(psum_p2m), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      fq.delete(); rq.delete();
      m_outst = 0; m_ovf = 1'b0; m_pe_en = 1'b0; m_m2p = '0; m_pks = '0; m_st = 0;
   endtask

   task automatic model_step();
      int   fs, rs, os;
      logic acc, issue, rpush, rpop;
      fs = fq.size(); rs = rq.size(); os = m_outst;
      acc   = caster_en && (tag == id);
      issue = (fs > 0) && (os < MAX_OUTST);
      rpush = pe_valid && (rs < RET_DEPTH);
      rpop  = (rs > 0) && ready;
      case (m_st)
         0: if (acc) begin m_st = 1; m_pks = kernel_size; end
         1: if (!caster_en) begin
               if (fs > 0 || os > 0) m_st = 2;
               else if (rs == 0)     m_st = 0;
            end
         default: if (acc) m_st = 1;
                  else if (fs == 0 && os == 0 && rs == 0) m_st = 0;
      endcase
      m_pe_en = issue;
      if (issue) m_m2p = fq.pop_front();
      if (acc) begin
         if (fq.size() < FWD_DEPTH) fq.push_back({ifmap_b2m, fltr_b2m, psum_b2m});
         else m_ovf = 1'b1;
      end
      if (rpop) rq.delete(0);
      if (rpush) rq.push_back({ifmap_p2m, fltr_p2m, psum_p2m});
      if (issue) m_outst++;
      if (rpush && os > 0) m_outst--;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      caster_en = 1'b0; tag = 2'd0; pe_valid = 1'b0; ready = 1'b0;
   endtask

   task automatic send_beat(input logic [1:0] tg, input logic [DW-1:0] ifm);
      caster_en = 1'b1; tag = tg; ifmap_b2m = ifm;
      fltr_b2m = DW'($urandom); psum_b2m = $urandom;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      model_clear();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (!(fq.size() == 0 && rq.size() == 0 && m_outst == 0 && m_st == 0) && n < 200) begin
         caster_en = 1'b0; ready = 1'b1;
         pe_valid  = (m_outst > 0);
         ifmap_p2m = DW'($urandom); fltr_p2m = DW'($urandom); psum_p2m = $urandom;
         tick();
         n++;
      end
      if (n >= 200) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: pipeline not empty after %0d cycles", n);
      end
      drive_idle();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL rst_pe_en: got %b want 0", pe_en); end
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid); end
      n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ovf_err); end
      n_tests++; if (pe_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pe_ready: got %b want 1", pe_ready); end
      n_tests++; if (pe_kernel_size !== 8'd0) begin n_fail++; $display("FAIL rst_pks: got %0d want 0", pe_kernel_size); end
      n_tests++; if ({ifmap_m2p, fltr_m2p, psum_m2p} !== 64'd0) begin n_fail++; $display("FAIL rst_m2p: got %h want 0", {ifmap_m2p, fltr_m2p, psum_m2p}); end
      n_tests++; if ({ifmap_m2b, fltr_m2b, psum_m2b} !== 64'd0) begin n_fail++; $display("FAIL rst_m2b: got %h want 0", {ifmap_m2b, fltr_m2b, psum_m2b}); end
      n_tests++; if (dut.state !== mc_pkg::MC_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want IDLE", dut.state); end
   endtask

   task automatic test_filter();
      for (int i = 0; i < 3; i++) begin
         send_beat(2'd1, DW'($urandom));
         tick();
         n_tests++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL filter_no_pe_en[%0d]: got %b want 0", i, pe_en); end
         n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL filter_ovf[%0d]: got %b want 0", i, ovf_err); end
      end
      send_beat(MY_ID, 16'h0011);
      tick();
      caster_en = 1'b0;
      n_tests++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL filter_lat1: got %b want 0", pe_en); end
      tick();
      n_tests++; if (pe_en !== 1'b1) begin n_fail++; $display("FAIL filter_lat2_pe_en: got %b want 1", pe_en); end
      n_tests++; if (ifmap_m2p !== 16'h0011) begin n_fail++; $display("FAIL filter_ifmap: got %h want 0011", ifmap_m2p); end
      drain();
   endtask

   task automatic test_credit();
      int          strobes = 0;
      logic [DW-1:0] ifm[4];
      logic [2:0]  fc;
      for (int i = 0; i < 4; i++) begin
         ifm[i] = DW'($urandom);
         send_beat(MY_ID, ifm[i]);
         tick();
         strobes += int'(pe_en);
      end
      caster_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         strobes += int'(pe_en);
      end
      n_tests++; if (strobes != 2) begin n_fail++; $display("FAIL credit_strobes: got %0d want 2", strobes); end
      fc = dut.u_fwd.wr_ptr - dut.u_fwd.rd_ptr;
      n_tests++; if (fc !== 3'd2) begin n_fail++; $display("FAIL credit_fwd_occ: got %0d want 2", fc); end
      pe_valid = 1'b1; ifmap_p2m = DW'($urandom); fltr_p2m = DW'($urandom); psum_p2m = $urandom;
      tick();
      pe_valid = 1'b0;
      n_tests++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL credit_ret_edge: got %b want 0", pe_en); end
      tick();
      n_tests++; if (pe_en !== 1'b1) begin n_fail++; $display("FAIL credit_third_pe_en: got %b want 1", pe_en); end
      n_tests++; if (ifmap_m2p !== ifm[2]) begin n_fail++; $display("FAIL credit_third_data: got %h want %h", ifmap_m2p, ifm[2]); end
      drain();
   endtask

   task automatic test_overflow();
      int         strobes = 0;
      logic [2:0] fc;
      for (int i = 0; i < 7; i++) begin
         send_beat(MY_ID, DW'($urandom));
         tick();
         strobes += int'(pe_en);
         if (i == 5) begin
            n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", ovf_err); end
         end
         if (i == 6) begin
            n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf_err); end
         end
      end
      caster_en = 1'b0;
      tick();
      strobes += int'(pe_en);
      n_tests++; if (strobes != 2) begin n_fail++; $display("FAIL ovf_strobes: got %0d want 2", strobes); end
      fc = dut.u_fwd.wr_ptr - dut.u_fwd.rd_ptr;
      n_tests++; if (fc !== 3'd4) begin n_fail++; $display("FAIL ovf_fwd_occ: got %0d want 4", fc); end
      drain();
      n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
      do_reset();
   endtask

   task automatic test_return_stall();
      for (int i = 0; i < 2; i++) begin
         send_beat(MY_ID, DW'($urandom));
         tick();
      end
      caster_en = 1'b0;
      tick(); tick();
      ready = 1'b0; pe_valid = 1'b1;
      ifmap_p2m = 16'h1111; fltr_p2m = 16'h2222; psum_p2m = 32'hDEAD_BEEF;
      tick();
      ifmap_p2m = 16'h3333; fltr_p2m = 16'h4444; psum_p2m = 32'h1234_5678;
      tick();
      pe_valid = 1'b0;
      n_tests++; if (pe_ready !== 1'b0) begin n_fail++; $display("FAIL stall_pe_ready: got %b want 0", pe_ready); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, valid); end
         n_tests++; if (psum_m2b !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_psum[%0d]: got %h want deadbeef", i, psum_m2b); end
      end
      ready = 1'b1;
      tick();
      n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL pop1_valid: got %b want 1", valid); end
      n_tests++; if ({ifmap_m2b, psum_m2b} !== {16'h3333, 32'h1234_5678}) begin n_fail++; $display("FAIL pop1_data: got %h want 333312345678", {ifmap_m2b, psum_m2b}); end
      tick();
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL pop2_valid: got %b want 0", valid); end
      ready = 1'b0;
      drain();
   endtask

   task automatic test_kernel_size();
      kernel_size = 8'd3;
      send_beat(MY_ID, DW'($urandom));
      tick();
      n_tests++; if (pe_kernel_size !== 8'd3) begin n_fail++; $display("FAIL ks_first: got %0d want 3", pe_kernel_size); end
      kernel_size = 8'd5;
      for (int i = 0; i < 2; i++) begin
         send_beat(MY_ID, DW'($urandom));
         tick();
         n_tests++; if (pe_kernel_size !== 8'd3) begin n_fail++; $display("FAIL ks_hold[%0d]: got %0d want 3", i, pe_kernel_size); end
      end
      drain();
      n_tests++; if (dut.state !== mc_pkg::MC_IDLE) begin n_fail++; $display("FAIL ks_drained_state: got %0d want IDLE", dut.state); end
      send_beat(MY_ID, DW'($urandom));
      tick();
      n_tests++; if (pe_kernel_size !== 8'd5) begin n_fail++; $display("FAIL ks_second: got %0d want 5", pe_kernel_size); end
      drain();
   endtask

   task automatic test_reset_midop();
      logic [2:0] fc;
      for (int i = 0; i < 5; i++) begin
         send_beat(MY_ID, DW'($urandom));
         tick();
      end
      caster_en = 1'b0;
      pe_valid = 1'b1; ifmap_p2m = DW'($urandom); fltr_p2m = DW'($urandom); psum_p2m = $urandom;
      tick();
      pe_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", valid); end
      n_tests++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL midrst_pe_en: got %b want 0", pe_en); end
      @(posedge clk); #1;
      fc = dut.u_fwd.wr_ptr - dut.u_fwd.rd_ptr;
      n_tests++; if (fc !== 3'd0) begin n_fail++; $display("FAIL midrst_fwd: got %0d want 0", fc); end
      n_tests++; if (dut.outst !== 4'd0) begin n_fail++; $display("FAIL midrst_outst: got %0d want 0", dut.outst); end
      n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b want 0", ovf_err); end
      n_tests++; if (dut.state !== mc_pkg::MC_IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want IDLE", dut.state); end
      rst = 1'b0;
      model_clear();
      send_beat(MY_ID, 16'h00A5);
      tick();
      caster_en = 1'b0;
      tick();
      n_tests++; if ({pe_en, ifmap_m2p} !== {1'b1, 16'h00A5}) begin n_fail++; $display("FAIL midrst_resume: got %b/%h want 1/00a5", pe_en, ifmap_m2p); end
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         caster_en   = ($urandom_range(0, 3) != 0);
         tag         = ($urandom_range(0, 2) == 0) ? 2'($urandom) : MY_ID;
         ifmap_b2m   = DW'($urandom); fltr_b2m = DW'($urandom); psum_b2m = $urandom;
         kernel_size = 8'($urandom);
         ready       = 1'($urandom);
         pe_valid    = (m_outst > 0) && ($urandom_range(0, 1) == 1);
         ifmap_p2m   = DW'($urandom); fltr_p2m = DW'($urandom); psum_p2m = $urandom;
         tick();
         n_tests++; if (pe_en !== m_pe_en) begin n_fail++; $display("FAIL rnd_pe_en@%0d: got %b want %b", c, pe_en, m_pe_en); end
         n_tests++; if ({ifmap_m2p, fltr_m2p, psum_m2p} !== m_m2p) begin n_fail++; $display("FAIL rnd_m2p@%0d: got %h want %h", c, {ifmap_m2p, fltr_m2p, psum_m2p}, m_m2p); end
         n_tests++; if (valid !== (rq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, valid, rq.size() > 0); end
         if (rq.size() > 0) begin
            n_tests++; if ({ifmap_m2b, fltr_m2b, psum_m2b} !== rq[0]) begin n_fail++; $display("FAIL rnd_m2b@%0d: got %h want %h", c, {ifmap_m2b, fltr_m2b, psum_m2b}, rq[0]); end
         end
         n_tests++; if (pe_ready !== (rq.size() < RET_DEPTH)) begin n_fail++; $display("FAIL rnd_pe_ready@%0d: got %b", c, pe_ready); end
         n_tests++; if (ovf_err !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b want %b", c, ovf_err, m_ovf); end
         n_tests++; if (pe_kernel_size !== m_pks) begin n_fail++; $display("FAIL rnd_pks@%0d: got %0d want %0d", c, pe_kernel_size, m_pks); end
         n_tests++; if (int'(dut.state) != m_st) begin n_fail++; $display("FAIL rnd_state@%0d: got %0d want %0d", c, dut.state, m_st); end
      end
      drain();
   endtask

   initial begin
      id = MY_ID; tag = 2'd0; caster_en = 1'b0; ready = 1'b0; pe_valid = 1'b0;
      ifmap_b2m = '0; fltr_b2m = '0; psum_b2m = '0; kernel_size = '0;
      ifmap_p2m = '0; fltr_p2m = '0; psum_p2m = '0; rst = 1'b0;
      test_reset();
      test_filter();
      test_credit();
      test_overflow();
      test_return_stall();
      test_kernel_size();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
